mole_scheduler: RTL and testbench

Sequences the ten hamster LEDs during play. Picks a pseudo-random position, raises that mole for a fixed dwell time, and detects a whack from the debounced hamster buttons. Emits one-cycle hit/miss pulses and keeps a two-digit BCD score. It sits between the game-state FSM (whose 2-bit state it follows) and the LED/seven-segment outputs.

---
 rtl/mole_scheduler.sv | 127 ++++++++++++
 tb/tb_mole_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Mole pop sequencer: LFSR-picked position, dwell/gap timing on 100 Hz ticks, hit/miss pulses, BCD score.
// Optional build macro WRONG_HIT_PENALTY_EN: a wrong button while a mole is up costs a point and pulses miss.
module mole_scheduler #(
  parameter int         DWELL_TICKS = 50,
  parameter int         GAP_TICKS   = 20,
  parameter logic [9:0] LFSR_SEED   = 10'h1A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] game_state,
  input  logic [9:0] hamster_btn,
  output logic [9:0] mole_led,
  output logic       active,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score_bcd
);

  localparam logic [1:0] GS_HOLD = 2'd0;
  localparam logic [1:0] GS_POP  = 2'd1;
  localparam logic [1:0] GS_HIT  = 2'd2;
  localparam int MAX_T = (DWELL_TICKS > GAP_TICKS) ? DWELL_TICKS : GAP_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {IDLE, GAP, UP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       lfsr;
  logic [3:0]       pos;
  logic [3:0]       cand, next_pos;
  logic             playing, btn_hit;

  assign playing = (game_state == GS_POP) || (game_state == GS_HIT);
  assign btn_hit = hamster_btn[pos];

  // Fold 10..15 onto 0..5, then step past a repeat of the last position.
  assign cand     = (lfsr[3:0] >= 4'd10) ? (lfsr[3:0] - 4'd10) : lfsr[3:0];
  assign next_pos = (cand != pos) ? cand : ((cand == 4'd9) ? 4'd0 : cand + 4'd1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)          return s;
    else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    else                     return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    if (s == 8'h00)          return s;
    else if (s[3:0] == 4'd0) return {s[7:4] - 4'd1, 4'd9};
    else                     return {s[7:4], s[3:0] - 4'd1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lfsr       <= LFSR_SEED;
      pos        <= 4'd0;
      mole_led   <= 10'b0;
      active     <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score_bcd  <= 8'h00;
    end else begin
      lfsr       <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (!playing) begin
        // A raised mole is dropped silently when play stops.
        state    <= IDLE;
        cnt      <= '0;
        mole_led <= 10'b0;
        active   <= 1'b0;
        if (game_state == GS_HOLD) score_bcd <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            state <= GAP;
            cnt   <= '0;
          end
          GAP: if (tick) begin
            if (cnt == CNT_W'(GAP_TICKS - 1)) begin
              state    <= UP;
              cnt      <= '0;
              pos      <= next_pos;
              mole_led <= 10'b1 << next_pos;
              active   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          UP: begin
            if (btn_hit) begin
              hit_pulse <= 1'b1;
              score_bcd <= bcd_inc(score_bcd);
              state     <= GAP;
              cnt       <= '0;
              mole_led  <= 10'b0;
              active    <= 1'b0;
            end else begin
`ifdef WRONG_HIT_PENALTY_EN
              if (|hamster_btn) begin
                miss_pulse <= 1'b1;
                score_bcd  <= bcd_dec(score_bcd);
              end
`endif
              if (tick) begin
                if (cnt == CNT_W'(DWELL_TICKS - 1)) begin
                  miss_pulse <= 1'b1;
                  state      <= GAP;
                  cnt        <= '0;
                  mole_led   <= 10'b0;
                  active     <= 1'b0;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: cycle model feeds a scoreboard queue, plus a score checkpoint table and corner sequences.
module tb_mole_scheduler;
  localparam int DW = 3;
  localparam int GP = 2;
  localparam logic [9:0] SEED = 10'h1A5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] game_state = 2'd0;
  logic [9:0] hamster_btn = 10'b0;
  logic [9:0] mole_led;
  logic       active, hit_pulse, miss_pulse;
  logic [7:0] score_bcd;

  mole_scheduler #(.DWELL_TICKS(DW), .GAP_TICKS(GP), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .game_state(game_state),
    .hamster_btn(hamster_btn), .mole_led(mole_led), .active(active),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score_bcd(score_bcd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] led;
    logic       act;
    logic       hit;
    logic       miss;
    logic [7:0] bcd;
  } exp_t;

  typedef struct {
    int         hits;
    logic [7:0] exp_bcd;
  } vec_t;

  exp_t sb[$];
  int total = 0, bad = 0;

  // Reference model state: 0 idle, 1 gap, 2 up; score held as plain decimal.
  logic [9:0] m_lfsr;
  int m_st, m_cnt, m_pos, m_score, tphase;

  function automatic logic [7:0] to_bcd(input int s);
    logic [3:0] t, u;
    t = 4'(s / 10);
    u = 4'(s % 10);
    return {t, u};
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic model_init();
    m_lfsr = SEED; m_st = 0; m_cnt = 0; m_pos = 0; m_score = 0; tphase = 0;
  endtask

  task automatic model_step(output exp_t e);
    int c;
    logic h, m;
    h = 0; m = 0;
    if (game_state != 2'd1 && game_state != 2'd2) begin
      m_st = 0;
      if (game_state == 2'd0) m_score = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_cnt = 0;
    end else if (m_st == 1) begin
      if (tick) begin
        if (m_cnt == GP - 1) begin
          c = int'(m_lfsr) % 16;
          if (c >= 10) c = c - 10;
          if (c == m_pos) c = (c + 1) % 10;
          m_pos = c; m_st = 2; m_cnt = 0;
        end else m_cnt++;
      end
    end else begin
      if (hamster_btn[m_pos]) begin
        h = 1;
        if (m_score < 99) m_score++;
        m_st = 1; m_cnt = 0;
      end else begin
`ifdef WRONG_HIT_PENALTY_EN
        if (hamster_btn != 10'b0) begin
          m = 1;
          if (m_score > 0) m_score--;
        end
`endif
        if (tick) begin
          if (m_cnt == DW - 1) begin
            m = 1; m_st = 1; m_cnt = 0;
          end else m_cnt++;
        end
      end
    end
    m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    e.led  = (m_st == 2) ? (10'b1 << m_pos) : 10'b0;
    e.act  = (m_st == 2);
    e.hit  = h;
    e.miss = m;
    e.bcd  = to_bcd(m_score);
  endtask

  // One clock: drive inputs, queue the model's prediction, compare after the edge.
  task automatic cyc(input logic [9:0] b);
    exp_t e, got;
    hamster_btn = b;
    tick = (tphase == 3);
    tphase = (tphase + 1) % 4;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = {mole_led, active, hit_pulse, miss_pulse, score_bcd};
    check("cycle_outputs", 32'(got), 32'(e));
  endtask

  task automatic wait_up();
    for (int i = 0; i < 200 && m_st != 2; i++) cyc(10'b0);
    if (m_st != 2) check("wait_up_timeout", 0, 1);
  endtask

  task automatic do_hits(input int n);
    logic [9:0] b;
    for (int k = 0; k < n; k++) begin
      wait_up();
      b = 10'b1 << m_pos;
      cyc(b);
      cyc(10'b0);
    end
  endtask

  initial begin
    vec_t vecs[5];
    logic [9:0] prev_led, b;
    int guard;
    vecs[0] = '{1, 8'h01};
    vecs[1] = '{8, 8'h09};
    vecs[2] = '{1, 8'h10};
    vecs[3] = '{89, 8'h99};
    vecs[4] = '{1, 8'h99};

    model_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(mole_led), 0);
    check("rst_active", 32'(active), 0);
    check("rst_hit", 32'(hit_pulse), 0);
    check("rst_miss", 32'(miss_pulse), 0);
    check("rst_score", 32'(score_bcd), 0);
    rst_n = 1'b1;

    // First pop: position drawn from the seeded LFSR.
    game_state = 2'd1;
    wait_up();
    check("first_pop_led", 32'(mole_led), 32'(10'b1 << m_pos));
    check("first_pop_active", 32'(active), 1);

    // Score checkpoints through the BCD carry and into saturation.
    foreach (vecs[i]) begin
      do_hits(vecs[i].hits);
      check("score_checkpoint", 32'(score_bcd), 32'(vecs[i].exp_bcd));
    end

    // Saturated hit still pulses.
    wait_up();
    b = 10'b1 << m_pos;
    cyc(b);
    check("sat_hit_pulse", 32'(hit_pulse), 1);
    check("sat_score", 32'(score_bcd), 32'h99);

    game_state = 2'd0;
    cyc(10'b0);
    check("hold_score_clear", 32'(score_bcd), 0);
    check("hold_led_off", 32'(mole_led), 0);
    game_state = 2'd2;

    // Timeout, then the next position must move.
    do_hits(3);
    wait_up();
    prev_led = mole_led;
    guard = 0;
    while (!miss_pulse && guard < 40) begin cyc(10'b0); guard++; end
    check("miss_seen", 32'(miss_pulse), 1);
    check("miss_score_kept", 32'(score_bcd), 32'h03);
    wait_up();
    total++;
    if (mole_led == prev_led) begin
      bad++;
      $display("FAIL new_pos_differs: got %0h previous %0h", mole_led, prev_led);
    end

    // Hit on the final dwell tick: hit wins.
    guard = 0;
    while (!(tphase == 3 && m_st == 2 && m_cnt == DW - 1) && guard < 60) begin cyc(10'b0); guard++; end
    check("expiry_align", 32'(m_cnt), 32'(DW - 1));
    b = 10'b1 << m_pos;
    cyc(b);
    check("expiry_hit", 32'(hit_pulse), 1);
    check("expiry_no_miss", 32'(miss_pulse), 0);

    // Stop mid-dwell: mole dropped, no miss, score frozen.
    wait_up();
    game_state = 2'd3;
    cyc(10'b0);
    check("stop_led", 32'(mole_led), 0);
    check("stop_no_miss", 32'(miss_pulse), 0);
    repeat (6) cyc(10'b1111111111);
    check("stop_score_frozen", 32'(score_bcd), 32'h04);

    // Wrong button at score 10.
    game_state = 2'd0;
    cyc(10'b0);
    game_state = 2'd1;
    do_hits(10);
    wait_up();
    guard = 0;
    while ((tphase == 3 || m_st != 2) && guard < 60) begin cyc(10'b0); guard++; end
    b = 10'b1 << ((m_pos + 1) % 10);
    cyc(b);
    check("wrong_still_up", 32'(active), 1);
`ifdef WRONG_HIT_PENALTY_EN
    check("wrong_miss", 32'(miss_pulse), 1);
    check("wrong_score", 32'(score_bcd), 32'h09);
`else
    check("wrong_miss", 32'(miss_pulse), 0);
    check("wrong_score", 32'(score_bcd), 32'h10);
`endif

    // Asynchronous reset mid-dwell.
    wait_up();
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(mole_led), 0);
    check("async_rst_active", 32'(active), 0);
    check("async_rst_pulses", 32'({hit_pulse, miss_pulse}), 0);
    check("async_rst_score", 32'(score_bcd), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
